// File: rtl/dff_pkg.sv
// Shared constants for the flip-flop library primitives.
package dff_pkg;

    // Widest register slice a single dff instance is expected to carry.
    localparam int DFF_MAX_WIDTH = 64;

endpackage : dff_pkg

// File: rtl/dff.sv
// Positive-edge D flip-flop with asynchronous active-high reset.
// Leaf storage primitive; wider registers instantiate it with WIDTH > 1.
module dff
    import dff_pkg::*;
#(
    parameter int                 WIDTH       = 1,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn
);

    logic [WIDTH-1:0] q_reg;

    // Capture d on every rising clock edge; reset overrides at once and masks clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= RESET_VALUE;
        end else begin
            q_reg <= d;
        end
    end

    assign q  = q_reg;
    // Complement is taken straight off the register, no second flop.
    assign qn = ~q_reg;

endmodule : dff

// File: tb/tb_dff.sv
// Directed testbench for dff: 1-bit default instance and 8-bit instance with RESET_VALUE 8'hA5.
`timescale 1ns/1ns
module tb_dff;

    logic       clk;
    logic       rst1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic [0:0] qn1;

    logic       rst8;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qn8;

    int errors;
    int checks;

    dff #(.WIDTH(1)) u_dff1 (
        .clk (clk),
        .rst (rst1),
        .d   (d1),
        .q   (q1),
        .qn  (qn1)
    );

    dff #(.WIDTH(8), .RESET_VALUE(8'hA5)) u_dff8 (
        .clk (clk),
        .rst (rst8),
        .d   (d8),
        .q   (q8),
        .qn  (qn8)
    );

    // Rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, obs, exp);
        end else begin
            $display("ok   %s t=%0t value=%h", tag, $time, obs);
        end
    endtask

    task automatic at(input int t);
        if (t > $time) #(t - $time);
    endtask

    task automatic check1(input string tag, input logic exp);
        check({tag, ".q"},  {63'd0, q1[0]},  {63'd0, exp});
        check({tag, ".qn"}, {63'd0, qn1[0]}, {63'd0, ~exp});
    endtask

    task automatic check8(input string tag, input logic [7:0] exp);
        check({tag, ".q8"},  {56'd0, q8},  {56'd0, exp});
        check({tag, ".qn8"}, {56'd0, qn8}, {56'd0, ~exp});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst1 = 1'b1;
        rst8 = 1'b1;
        d1   = 1'b0;
        d8   = 8'h00;

        at(2);  rst1 = 1'b0; rst8 = 1'b0;
        at(3);  check1("reset", 1'b0);
                check8("reset8", 8'hA5);
        at(6);  check1("cap_e5", 1'b0);
                check8("cap8_e5", 8'h00);

        at(10); d1 = 1'b1; d8 = 8'h3C;
        at(12); check1("hold_pre_e15", 1'b0);
                check8("hold8_pre_e15", 8'h00);
        at(16); check1("cap_e15", 1'b1);
                check8("cap8_e15", 8'h3C);
        at(20); d1 = 1'b0; d8 = 8'hFF;
        at(26); check1("cap_e25", 1'b0);
                check8("cap8_e25", 8'hFF);
        at(30); d1 = 1'b1; d8 = 8'h01;
        at(36); check1("cap_e35", 1'b1);
                check8("cap8_e35", 8'h01);

        // Mid-cycle asynchronous reset
        at(37); rst1 = 1'b1; rst8 = 1'b1;
        at(38); check1("async_rst", 1'b0);
                check8("async_rst8", 8'hA5);
        at(46); check1("rst_masks_e45", 1'b0);
                check8("rst8_masks_e45", 8'hA5);

        // Release is not an update event
        at(48); rst1 = 1'b0; rst8 = 1'b0; d1 = 1'b1; d8 = 8'h96;
        at(51); check1("release_hold", 1'b0);
                check8("release8_hold", 8'hA5);
        at(56); check1("first_cap_e55", 1'b1);
                check8("first_cap8_e55", 8'h96);

        // Glitchy d entirely between edges; only value at edge 65 matters
        at(57); d1 = 1'b0;
        at(59); d1 = 1'b1;
        at(61); d1 = 1'b0;
        at(62); check1("hold_glitch", 1'b1);
        at(66); check1("cap_e65", 1'b0);

        // Reset asserted exactly at rising edge 75 with d=1
        at(67); d1 = 1'b1; d8 = 8'h3C;
        at(75); rst1 = 1'b1; rst8 = 1'b1;
        at(76); check1("rst_coincide", 1'b0);
                check8("rst8_coincide", 8'hA5);
        at(78); rst1 = 1'b0; rst8 = 1'b0;
        at(86); check1("cap_e85", 1'b1);
                check8("cap8_e85", 8'h3C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dff

// File: doc/dff.md
Name: dff

Overview:
- Positive-edge-triggered D flip-flop: captures input `d` on every rising edge of `clk` and presents it on `q`.
- Asynchronous active-high reset.
- Leaf storage primitive in the Flipflops library, used directly or replicated as a register bit-slice by higher-level sequential blocks (shift registers, counters).

Parameters:
- WIDTH, 1, data width in bits of `d`/`q`/`qn`; legal range 1..64.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into `q` while `rst` is asserted.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- d  input  WIDTH  data input, sampled at rising edge of `clk`.
- q  output  WIDTH  registered data output.
- qn  output  WIDTH  bitwise complement of `q`, purely combinational from the register (no extra flop).

Behaviour:
- One clock (`clk`); reset is asynchronous and active-high (`rst`).
- Reset:
  - On rising edge of `rst`, or whenever `rst` is high, `q` = RESET_VALUE immediately, without waiting for a clock edge.
  - `qn` = ~RESET_VALUE.
  - While `rst` is high, clock edges are ignored.
- Release:
  - Deassertion of `rst` is not itself an update event.
  - The first capture is the first rising `clk` edge at which `rst` is low.
- Capture:
  - At each rising `clk` edge with `rst` low, `q` <= `d` (value of `d` just before the edge).
  - Latency is exactly one edge: a `d` change between edges n-1 and n appears on `q` after edge n.
  - `q` holds between edges regardless of `d` activity, including changes on the falling edge.
- Simultaneous events: `rst` rising coincident with a `clk` rising edge → reset wins; `q` = RESET_VALUE.
- Reset mid-cycle: asserting `rst` between clock edges clears `q` at once; the captured value is lost.
- Width: all WIDTH bits are captured in parallel; no per-bit enables.
- No enable input: every non-reset rising edge loads `d`.
- Initial state before any reset or clock edge is X in simulation. The block must not rely on an initial statement; benches must apply reset or at least one clock edge before checking.
- Implementation:
  - Single sequential process sensitive to posedge `clk` or posedge `rst`, using non-blocking assignment.
  - `qn` by continuous assignment.
  - No latches, no gated clocks.

Decomposition:
- No shared package required.
- RESET_VALUE default is defined locally.
- No sub-module; this block is itself the leaf primitive.
- Wider registers in the codebase instantiate `dff` with WIDTH > 1 rather than wrapping it.

Test Plan:
- Basic capture, WIDTH=1, 10-unit clock (rising edges at 5, 15, 25, 35, 45, 55):
  - Stimulus: `rst` pulsed 1 during t=0..2, `d`=0; `d` changes on falling edges: `d`=1 at t=10, 0 at t=20, 1 at t=30, 0 at t=40; run to t=60.
  - Required: `q`=0 at t=5; `q`=1 from t=15; `q`=0 from t=25; `q`=1 from t=35; `q`=0 from t=45 through t=60. `qn` is always ~`q`.
- Hold between edges: toggle `d` 0→1→0 entirely between two rising edges -> `q` unchanged; `q` equals the `d` value present at the next edge.
- Asynchronous reset mid-cycle:
  - Stimulus: `q`=1; assert `rst` at t=37 (between edges).
  - Required: `q`=0 by t=37+delta, not at t=45; `q` stays 0 across edges while `rst`=1 even with `d`=1.
- Reset release:
  - Stimulus: deassert `rst` at t=48 with `d`=1.
  - Required: `q` stays 0 until the rising edge at t=55, then `q`=1.
- Reset/clock coincidence: assert `rst` exactly at a rising `clk` edge with `d`=1 -> `q`=RESET_VALUE (0).
- Parameterised width: WIDTH=8, RESET_VALUE=8'hA5.
  - Reset -> `q`=8'hA5, `qn`=8'h5A.
  - `d`=8'h3C at an edge -> `q`=8'h3C, `qn`=8'hC3 after that edge.
